// File: rtl/madd_pkg.sv
// rtl/madd_pkg.sv - shared types and defaults for the multiply-add scheduler
package madd_pkg;

    localparam int DATA_W   = 32;
    localparam int NREQ_DEF = 4;
    localparam int CNTW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/MADD.sv
// rtl/MADD.sv - registered multiply-add, Z = A*B + C mod 2^32, one clock latency
// Ports: CLK clock; A/B/C operands; Z registered result.
module MADD
    import madd_pkg::*;
(
    input  logic              CLK,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] C,
    output logic [DATA_W-1:0] Z
);

    // Low bits of the product are identical for signed and unsigned operands.
    always_ff @(posedge CLK) begin
        Z <= A * B + C;
    end

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter
// Ports: req request vector; ptr last granted index; en grant enable;
//        gnt one-hot grant; gnt_idx encoded grant index.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    int idx;

    // Walk from the farthest candidate (ptr itself) back to ptr+1 so the
    // last hit, which overrides earlier ones, is the nearest after ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        if (en) begin
            for (int k = NREQ; k >= 1; k--) begin
                idx = (int'(ptr) + k) % NREQ;
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx[IDW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/madd_sched.sv
// rtl/madd_sched.sv - round-robin scheduler sharing one MADD among NREQ requesters
// Ports: CLK clock; RST sync active-high reset;
//        REQ_VALID/REQ_READY/REQ_A/REQ_B/REQ_C request handshake and operands;
//        RSP_VALID/RSP_READY/RSP_ID/RSP_Z tagged response with backpressure;
//        BUSY not idle; OPS_DONE wrapping count of response handshakes.
module madd_sched
    import madd_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = CNTW_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        REQ_VALID,
    output logic [NREQ-1:0]        REQ_READY,
    input  logic [DATA_W*NREQ-1:0] REQ_A,
    input  logic [DATA_W*NREQ-1:0] REQ_B,
    input  logic [DATA_W*NREQ-1:0] REQ_C,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [IDW-1:0]         RSP_ID,
    output logic [DATA_W-1:0]      RSP_Z,
    output logic                   BUSY,
    output logic [CNTW-1:0]        OPS_DONE
);

    state_t            state_q;
    state_t            state_d;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    win_idx;
    logic [NREQ-1:0]   gnt;
    logic              grant_en;
    logic              accept;
    logic              rsp_fire;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] opc_q;
    logic [DATA_W-1:0] madd_z;
    logic [CNTW-1:0]   ops_q;

    // New work may only enter when the unit is free or is being freed this cycle.
    assign grant_en = !RST && ((state_q == IDLE) || ((state_q == DONE) && RSP_READY));

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (REQ_VALID),
        .ptr     (ptr_q),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (win_idx)
    );

    assign REQ_READY = gnt;
    assign accept    = |gnt;
    assign rsp_fire  = (state_q == DONE) && RSP_READY;

    always_comb begin
        state_d   = state_q;
        RSP_VALID = 1'b0;
        BUSY      = 1'b1;
        case (state_q)
            IDLE: begin
                BUSY = 1'b0;
                if (accept) state_d = EXEC;
            end
            EXEC: state_d = DONE;
            DONE: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) state_d = accept ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q <= win_idx;
                id_q  <= win_idx;
                opa_q <= REQ_A[win_idx*DATA_W +: DATA_W];
                opb_q <= REQ_B[win_idx*DATA_W +: DATA_W];
                opc_q <= REQ_C[win_idx*DATA_W +: DATA_W];
            end
            if (rsp_fire) ops_q <= ops_q + CNTW'(1);
        end
    end

    // Operands stay put until the next accept, so Z holds through DONE stalls.
    MADD u_madd (
        .CLK (CLK),
        .A   (opa_q),
        .B   (opb_q),
        .C   (opc_q),
        .Z   (madd_z)
    );

    assign RSP_ID   = id_q;
    assign RSP_Z    = RSP_VALID ? madd_z : '0;
    assign OPS_DONE = ops_q;

endmodule

// File: tb/tb_madd_sched.sv
// tb/tb_madd_sched.sv - self-checking bench for madd_sched
module tb_madd_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ-1:0]   REQ_READY;
    logic [32*NREQ-1:0] REQ_A;
    logic [32*NREQ-1:0] REQ_B;
    logic [32*NREQ-1:0] REQ_C;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [IDW-1:0]    RSP_ID;
    logic [31:0]       RSP_Z;
    logic              BUSY;
    logic [CNTW-1:0]   OPS_DONE;

    madd_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .REQ_C     (REQ_C),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_ID    (RSP_ID),
        .RSP_Z     (RSP_Z),
        .BUSY      (BUSY),
        .OPS_DONE  (OPS_DONE)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          id;
        logic [31:0] z;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] z;
    } vec_t;

    exp_t            sb[$];
    logic [CNTW-1:0] ops_model;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        REQ_A[32*i +: 32] = a;
        REQ_B[32*i +: 32] = b;
        REQ_C[32*i +: 32] = c;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scoreboard: expectation pushed on each accepted request, popped on each response.
    always @(negedge CLK) begin : monitor
        exp_t        e;
        logic [31:0] za;
        if (RST) begin
            sb.delete();
            ops_model = '0;
        end else begin
            check("ops_done_model", OPS_DONE, ops_model);
            check("req_ready_onehot", ($countones(REQ_READY) <= 1), 1);
            check("req_ready_subset", (REQ_READY & ~REQ_VALID), 0);
            if (!RSP_VALID) check("rsp_z_zero_when_invalid", RSP_Z, 0);
            if (RSP_VALID && RSP_READY) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_response: got id %0d z 0x%0h, expected none", RSP_ID, RSP_Z);
                end else begin
                    e = sb.pop_front();
                    check("sb_rsp_id", RSP_ID, e.id);
                    check("sb_rsp_z", RSP_Z, e.z);
                end
                ops_model = ops_model + 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (REQ_VALID[i] && REQ_READY[i]) begin
                    za   = REQ_A[32*i +: 32] * REQ_B[32*i +: 32] + REQ_C[32*i +: 32];
                    e.id = i;
                    e.z  = za;
                    sb.push_back(e);
                end
            end
        end
    end

    vec_t vecs[7];
    int   gcyc[$];
    int   gidx[$];
    int   exp_order[5];

    initial begin
        vecs[0] = '{2, 32'd3,          32'd5,          32'd7,          32'd22};
        vecs[1] = '{0, 32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFE};
        vecs[2] = '{1, 32'h0001_0000,  32'h0001_0000,  32'd5,          32'd5};
        vecs[3] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1};
        vecs[4] = '{0, 32'h8000_0000,  32'd2,          32'd1,          32'd1};
        vecs[5] = '{1, 32'd12345,      32'd6789,       32'hFFFF_FFFF,  32'd83810204};
        vecs[6] = '{2, 32'hDEAD_BEEF,  32'd0,          32'h1234_5678,  32'h1234_5678};
        exp_order = '{0, 1, 2, 3, 0};

        RST       = 1'b1;
        REQ_VALID = '0;
        REQ_A     = '0;
        REQ_B     = '0;
        REQ_C     = '0;
        RSP_READY = 1'b1;

        // Reset values, with requests pending to prove grants are blocked.
        REQ_VALID = '1;
        step();
        step();
        smp();
        check("rst_req_ready", REQ_READY, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_id", RSP_ID, 0);
        check("rst_rsp_z", RSP_Z, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ops_done", OPS_DONE, 0);
        step();
        RST       = 1'b0;
        REQ_VALID = '0;
        smp();
        check("post_rst_busy", BUSY, 0);
        check("post_rst_rsp_valid", RSP_VALID, 0);
        step();

        // Single-requester vectors: grant in cycle 0, result in cycle 2, idle in cycle 3.
        for (int v = 0; v < 7; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].c);
            REQ_VALID = onehot(vecs[v].id);
            smp();
            check("vec_grant", REQ_READY, onehot(vecs[v].id));
            step();
            REQ_VALID = '0;
            smp();
            check("vec_exec_busy", BUSY, 1);
            check("vec_exec_no_rsp", RSP_VALID, 0);
            step();
            smp();
            check("vec_rsp_valid", RSP_VALID, 1);
            check("vec_rsp_id", RSP_ID, vecs[v].id);
            check("vec_rsp_z", RSP_Z, vecs[v].z);
            step();
            smp();
            check("vec_idle_busy", BUSY, 0);
            step();
        end

        // Round robin with all requesters valid from reset.
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 10, i);
        REQ_VALID = '1;
        for (int c = 0; c < 10; c++) begin
            smp();
            if (|REQ_READY) begin
                gcyc.push_back(c);
                gidx.push_back($clog2(REQ_READY));
            end
            if (c == 9) check("rr_ops_done_4", OPS_DONE, 4);
            step();
        end
        REQ_VALID = '0;
        check("rr_grant_count", gidx.size(), 5);
        for (int k = 0; k < 5 && k < gidx.size(); k++) begin
            check("rr_grant_order", gidx[k], exp_order[k]);
            check("rr_grant_cycle", gcyc[k], 2 * k);
        end
        repeat (4) step();

        // Backpressure: five stalled DONE cycles, then same-cycle release and accept.
        set_req(1, 32'd100, 32'd3, 32'd7);
        REQ_VALID = 4'b0010;
        smp();
        check("bp_grant", REQ_READY, 4'b0010);
        step();
        REQ_VALID = 4'b1000;
        set_req(3, 32'd9, 32'd9, 32'd9);
        RSP_READY = 1'b0;
        smp();
        check("bp_exec_no_grant", REQ_READY, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            smp();
            check("bp_hold_valid", RSP_VALID, 1);
            check("bp_hold_id", RSP_ID, 1);
            check("bp_hold_z", RSP_Z, 32'd307);
            check("bp_hold_no_grant", REQ_READY, 0);
            step();
        end
        RSP_READY = 1'b1;
        smp();
        check("bp_release_grant", REQ_READY, 4'b1000);
        check("bp_release_id", RSP_ID, 1);
        step();
        REQ_VALID = '0;
        smp();
        check("bp_next_exec", RSP_VALID, 0);
        step();
        smp();
        check("bp_next_id", RSP_ID, 3);
        check("bp_next_z", RSP_Z, 32'd90);
        step();

        // Reset while EXEC discards the operation and restores the pointer.
        set_req(2, 32'd1, 32'd1, 32'd1);
        REQ_VALID = 4'b0100;
        smp();
        check("rx_grant", REQ_READY, 4'b0100);
        step();
        REQ_VALID = '0;
        RST       = 1'b1;
        smp();
        check("rx_in_exec", BUSY, 1);
        step();
        RST = 1'b0;
        smp();
        check("rx_rsp_valid", RSP_VALID, 0);
        check("rx_ops_done", OPS_DONE, 0);
        check("rx_busy", BUSY, 0);
        step();
        set_req(0, 32'd6, 32'd7, 32'd8);
        set_req(3, 32'd1, 32'd2, 32'd3);
        REQ_VALID = 4'b1001;
        smp();
        check("rx_ptr_reset", REQ_READY, 4'b0001);
        step();
        REQ_VALID = '0;
        smp();
        check("rx_exec_no_rsp", RSP_VALID, 0);
        step();
        smp();
        check("rx_rsp_id", RSP_ID, 0);
        check("rx_rsp_z", RSP_Z, 32'd50);
        step();
        repeat (2) step();

        // Counter wrap: 256 responses on an 8-bit counter.
        RST = 1'b1;
        step();
        RST = 1'b0;
        set_req(0, 32'd2, 32'd3, 32'd4);
        REQ_VALID = 4'b0001;
        for (int c = 0; c < 514; c++) begin
            smp();
            if (c == 511) check("wrap_all_ones", OPS_DONE, 8'hFF);
            if (c == 513) check("wrap_zero", OPS_DONE, 8'h00);
            step();
        end
        REQ_VALID = '0;
        repeat (4) step();

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/madd_sched.md
# madd_sched

Round-robin scheduler that shares one registered multiply-add unit (`MADD`, Z = A*B + C mod 2^32, one clock of latency) among NREQ requesters. Each requester makes an operand request with a valid/ready handshake. The scheduler holds the winner's operands steady in registers, waits for the unit's registered result, and returns it on a single tagged response port with backpressure. It sits between the functional-unit issue logic and the `MADD` instance, and it instantiates `MADD` itself.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-ID width, equal to clog2(NREQ)
- CNTW, 16, width of the completed-operation counter

- CLK  in  1  clock; all state updates on posedge
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  NREQ  per-requester request valid
- REQ_READY  out  NREQ  one-hot grant; a request is accepted when VALID and READY are both high
- REQ_A, REQ_B, REQ_C  in  32*NREQ  flattened operands; requester i uses bits [32i+31:32i]
- RSP_VALID  out  1  result valid
- RSP_READY  in  1  consumer accepts the result
- RSP_ID  out  IDW  index of the requester that owns the result
- RSP_Z  out  32  result; forced to 0 whenever RSP_VALID is 0
- BUSY  out  1  high when state is not IDLE
- OPS_DONE  out  CNTW  count of completed response handshakes; wraps

## Operation
- State machine with three states:
  - IDLE: no operation in flight.
  - EXEC: operands are loaded and `MADD` is computing.
  - DONE: the result is being presented on the response port.
- Transitions:
  - IDLE → EXEC on any accept.
  - EXEC → DONE unconditionally.
  - DONE → IDLE on RSP_READY with no accept.
  - DONE → EXEC on RSP_READY with an accept in the same cycle.
  - DONE → DONE while RSP_READY is low.
- Grant window: grants are issued only in IDLE, or in DONE while RSP_READY is high. REQ_READY is all-zero in EXEC, in DONE while RSP_READY is low, and while RST is high.
- REQ_READY is combinational from REQ_VALID, the state, RSP_READY and the arbitration pointer. At most one bit is set, and only for a requester whose VALID is high.
- Round-robin arbitration:
  - The pointer holds the last granted index.
  - The search starts at pointer+1 mod NREQ.
  - The pointer updates only on an accept.
- On accept, the operand registers OPA/OPB/OPC load the winner's A/B/C and the ID register loads the winner's index. The operand registers drive `MADD` and stay unchanged until the next accept. Because `MADD` recomputes every clock, this is what keeps Z stable across DONE stalls.
- Arithmetic: the result is the low 32 bits of A*B + C, treating operands as two's complement. Overflow wraps and no flag is raised.
- RSP_ID equals the ID register. RSP_VALID is high exactly in DONE.
- OPS_DONE increments on each RSP_VALID && RSP_READY and wraps from all-ones to 0.

## Timing
- Accept at edge e (state moves to EXEC), then `MADD` registers Z at edge e+1 (state moves to DONE). RSP_VALID is high in the cycle after e+1: 2 cycles from accept to result.
- Peak throughput is one operation per 2 cycles, achieved with RSP_READY held high and back-to-back accepts made from DONE.
- During backpressure, RSP_VALID, RSP_ID and RSP_Z hold stable until the handshake completes.
- Reset values while RST is high and on the edge after it:
  - State IDLE.
  - REQ_READY 0, RSP_VALID 0, RSP_ID 0, RSP_Z 0, BUSY 0, OPS_DONE 0.
  - OPA/OPB/OPC 0.
  - Pointer NREQ-1, so requester 0 has first priority.
- Reset in EXEC or DONE discards the operation in flight. No response is produced for it.
- Simultaneous events in DONE with RSP_READY high: the response handshake and a new accept complete on the same edge. The counter increments and the operands reload.
- A requester that drops VALID before being granted is simply skipped; there is no penalty.

## Structure
- Shared package `madd_pkg` holds:
  - state enum (IDLE/EXEC/DONE),
  - DATA_W = 32,
  - the default NREQ/CNTW.
- Sub-module `rr_arb`: parameterised NREQ round-robin arbiter. Inputs are request vector, pointer and enable; output is a one-hot grant and the encoded index.
- `madd_sched` contains the FSM, operand/ID registers, the counter, and the `MADD` instance.

## Test plan
- Single request, ID 2 (A=3, B=5, C=7), RSP_READY high → accepted in cycle 0; RSP_VALID in cycle 2 with RSP_ID=2 and RSP_Z=22; BUSY low in cycle 3.
- All four VALIDs held high after reset with RSP_READY high → grant order 0, 1, 2, 3, 0 with accepts every 2 cycles; OPS_DONE=4 after the fourth response.
- RSP_READY low for 5 cycles while in DONE → RSP_Z, RSP_ID and RSP_VALID are constant and REQ_READY=0; on release, the next pending requester is accepted in the same cycle.
- Wrap arithmetic:
  - A=0xFFFFFFFF, B=2, C=0 → Z=0xFFFFFFFE.
  - A=0x00010000, B=0x00010000, C=5 → Z=5.
- RST pulsed in EXEC → next cycle RSP_VALID=0, OPS_DONE=0, pointer reset. No stale response ever appears; the next request from requester 0 completes normally.
- OPS_DONE preset to 0xFFFF by running 65535 operations, then one more response → OPS_DONE=0x0000.
